// File: rtl/seg_digit_reader_pkg.sv
// Shared definitions for the 7-segment display bus: segment bit order, the
// sixteen legal active-low hex glyphs, and the default stability window.
package seg_digit_reader_pkg;

    localparam int STABLE_CYCLES_DEFAULT = 4;

    // Bit position of each segment within seg_n.
    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_bit_e;

    localparam logic [6:0] SEG_HEX_0 = 7'h40;
    localparam logic [6:0] SEG_HEX_1 = 7'h79;
    localparam logic [6:0] SEG_HEX_2 = 7'h24;
    localparam logic [6:0] SEG_HEX_3 = 7'h30;
    localparam logic [6:0] SEG_HEX_4 = 7'h19;
    localparam logic [6:0] SEG_HEX_5 = 7'h12;
    localparam logic [6:0] SEG_HEX_6 = 7'h02;
    localparam logic [6:0] SEG_HEX_7 = 7'h78;
    localparam logic [6:0] SEG_HEX_8 = 7'h00;
    localparam logic [6:0] SEG_HEX_9 = 7'h18;
    localparam logic [6:0] SEG_HEX_A = 7'h08;
    localparam logic [6:0] SEG_HEX_B = 7'h03;
    localparam logic [6:0] SEG_HEX_C = 7'h46;
    localparam logic [6:0] SEG_HEX_D = 7'h21;
    localparam logic [6:0] SEG_HEX_E = 7'h06;
    localparam logic [6:0] SEG_HEX_F = 7'h0E;

    // Indexed by nibble value: SEG_TABLE[n] is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        SEG_HEX_F, SEG_HEX_E, SEG_HEX_D, SEG_HEX_C,
        SEG_HEX_B, SEG_HEX_A, SEG_HEX_9, SEG_HEX_8,
        SEG_HEX_7, SEG_HEX_6, SEG_HEX_5, SEG_HEX_4,
        SEG_HEX_3, SEG_HEX_2, SEG_HEX_1, SEG_HEX_0
    };

endpackage

// File: rtl/seg_digit_reader_seg_to_hex.sv
// Combinational glyph decoder: active-low 7-segment pattern to hex nibble.
// legal is low for any pattern that is not one of the sixteen hex glyphs.
module seg_to_hex
    import seg_digit_reader_pkg::*;
(
    input  logic [6:0] seg_n,
    output logic [3:0] nibble,
    output logic       legal
);

    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_n == SEG_TABLE[i]) begin
                nibble = 4'(i);
                legal  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_digit_reader.sv
// Reads back a multiplexed 4-digit segment bus: synchronizes, waits for a stable
// pattern, decodes it and holds the 16-bit value with per-digit valid flags.
module seg_digit_reader
    import seg_digit_reader_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        bad_pattern
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);

    logic [10:0]   sync1, sync2, prev;
    logic [CW-1:0] cnt;
    logic          match, attempt;
    logic [3:0]    sel;
    logic          blank, single;
    logic [1:0]    idx;
    logic [3:0]    nibble;
    logic          legal;
    logic [3:0]    seen, seen_next, seen_hit;
    logic [15:0]   digits_next;
    logic [3:0]    valid_next;
    logic          frame_next, bad_next;

    // All-ones reset reads as a blank display, so nothing decodes out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '1;
            sync2 <= '1;
            prev  <= '1;
        end else begin
            sync1 <= {an_n, seg_n};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign match   = (sync2 == prev);
    assign attempt = match && (cnt == CW'(STABLE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!match) begin
            cnt <= '0;
        end else if (cnt != CW'(STABLE_CYCLES)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign sel    = ~sync2[10:7];
    assign blank  = (sel == 4'd0);
    assign single = !blank && ((sel & (sel - 4'd1)) == 4'd0);

    always_comb begin
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) idx = 2'(i);
        end
    end

    seg_to_hex u_seg_to_hex (
        .seg_n  (sync2[6:0]),
        .nibble (nibble),
        .legal  (legal)
    );

    always_comb begin
        digits_next = digits;
        valid_next  = digit_valid;
        seen_next   = seen;
        seen_hit    = seen | sel;
        frame_next  = 1'b0;
        bad_next    = 1'b0;
        if (attempt && !blank) begin
            if (!single) begin
                bad_next = 1'b1;
            end else if (legal) begin
                digits_next[{idx, 2'b00} +: 4] = nibble;
                valid_next[idx]                = 1'b1;
                // Completing the mask closes the frame and starts the next one.
                if (seen_hit == 4'hF) begin
                    frame_next = 1'b1;
                    seen_next  = 4'h0;
                end else begin
                    seen_next  = seen_hit;
                end
            end else begin
                bad_next        = 1'b1;
                valid_next[idx] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digits      <= '0;
            digit_valid <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            bad_pattern <= 1'b0;
        end else begin
            digits      <= digits_next;
            digit_valid <= valid_next;
            seen        <= seen_next;
            frame_done  <= frame_next;
            bad_pattern <= bad_next;
        end
    end

endmodule
